icache_responder: RTL

- Instruction-cache responder on the slave side of the fetch-stage I$/TLB handshake.
- Fetch issues REQ_VALID + IDX/VPN, then asserts RESP_READY the next cycle; this block returns a 128-bit line one cycle later on a hit.
- Direct-mapped, blocking, single outstanding refill to a simple memory port.
- Identity translation; fetch faults are raised for addresses beyond the physical range.

---
 rtl/icache_responder_pkg.sv | 25 ++
 rtl/icache_line_array.sv | 55 +++++
 rtl/icache_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/icache_responder_pkg.sv
// Shared definitions for the instruction-cache responder.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - Line geometry: LINE_BITS, OFFSET_BITS
//   - Helpers deriving index/tag widths from NUM_LINES and PADDR_BITS
package icache_responder_pkg;

  localparam int unsigned LINE_BITS   = 128;
  localparam int unsigned OFFSET_BITS = 4;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLookup   = 3'd1;
  localparam logic [2:0] StResp     = 3'd2;
  localparam logic [2:0] StMissReq  = 3'd3;
  localparam logic [2:0] StMissWait = 3'd4;

  function automatic int unsigned index_bits(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned num_lines,
                                           input int unsigned paddr_bits);
    return paddr_bits - OFFSET_BITS - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: tag and data flop arrays plus a valid vector.
// Ports:
//   CLK, RST            clock, synchronous active-low reset (clears valid only)
//   rd_index            combinational read index
//   rd_tag/rd_data/rd_valid  read results
//   wr_en/wr_index/wr_tag/wr_data/wr_valid  fill write port
//   flush               clears every valid bit at the next edge (wins over wr_valid)
module icache_line_array
  import icache_responder_pkg::*;
#(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned TAG_BITS  = 22
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [$clog2(NUM_LINES)-1:0]   rd_index,
  output logic [TAG_BITS-1:0]            rd_tag,
  output logic [LINE_BITS-1:0]           rd_data,
  output logic                           rd_valid,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_LINES)-1:0]   wr_index,
  input  logic [TAG_BITS-1:0]            wr_tag,
  input  logic [LINE_BITS-1:0]           wr_data,
  input  logic                           wr_valid,
  input  logic                           flush
);

  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_index] = wr_valid;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag/data need no reset: an entry is only trusted through its valid bit.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Instruction-cache responder on the slave side of the fetch I$/TLB handshake.
// Direct-mapped, blocking, one outstanding single-beat refill, identity translation.
// Ports:
//   CLK, RST                        clock, synchronous active-low reset
//   ICACHE_REQ_*/ICACHE_RESP_READY  fetch request and response handshake
//   ICACHE_INVALIDATE               flush all lines
//   TLB_REQ_*/TLB_RESP_*            translation request; fault flag on out-of-range VPN
//   PTWINVALIDATE                   tied 0
//   MEM_REQ_*/MEM_RESP_*            refill port
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned PADDR_BITS = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ICACHE_REQ_VALID,
  input  logic [11:0]           ICACHE_REQ_BITS_IDX,
  input  logic                  ICACHE_REQ_BITS_KILL,
  input  logic                  ICACHE_RESP_READY,
  input  logic                  ICACHE_INVALIDATE,
  input  logic                  TLB_REQ_VALID,
  input  logic [27:0]           TLB_REQ_BITS_VPN,
  output logic                  ICACHE_RESP_VALID,
  output logic [LINE_BITS-1:0]  ICACHE_RESP_BITS_DATABLOCK,
  output logic                  TLB_RESP_MISS,
  output logic                  TLB_RESP_XCPT_IF,
  output logic                  PTWINVALIDATE,
  output logic                  MEM_REQ_VALID,
  output logic [PADDR_BITS-1:0] MEM_REQ_ADDR,
  input  logic                  MEM_REQ_READY,
  input  logic                  MEM_RESP_VALID,
  input  logic [LINE_BITS-1:0]  MEM_RESP_DATA
);

  localparam int unsigned IDX_BITS  = index_bits(NUM_LINES);
  localparam int unsigned TAG_BITS  = tag_bits(NUM_LINES, PADDR_BITS);
  localparam int unsigned LINE_ADDR = PADDR_BITS - OFFSET_BITS;
  localparam int unsigned VA_LINE   = 28 + 12 - OFFSET_BITS;

  logic [2:0]                  state_q, state_d;
  logic [11:OFFSET_BITS]       idx_q, idx_d;
  logic [27:0]                 vpn_q, vpn_d;
  logic                        drop_fill_q, drop_fill_d;
  logic [LINE_BITS-1:0]        datablock_q, datablock_d;
  logic [LINE_ADDR-1:0]        miss_line_q, miss_line_d;

  // The byte offset within a line selects nothing: the whole line is returned.
  logic unused_offset;
  assign unused_offset = ^ICACHE_REQ_BITS_IDX[OFFSET_BITS-1:0];

  logic [VA_LINE-1:0]   va_line;
  logic [LINE_ADDR-1:0] pa_line;
  logic                 fault;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 hit;
  logic                 fill_en;

  assign va_line = {vpn_q, idx_q};
  assign pa_line = va_line[LINE_ADDR-1:0];
  assign fault   = |(va_line >> LINE_ADDR);
  assign hit     = rd_valid && (rd_tag == pa_line[LINE_ADDR-1 -: TAG_BITS]);

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .CLK      (CLK),
    .RST      (RST),
    .rd_index (pa_line[IDX_BITS-1:0]),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (fill_en),
    .wr_index (miss_line_q[IDX_BITS-1:0]),
    .wr_tag   (miss_line_q[LINE_ADDR-1 -: TAG_BITS]),
    .wr_data  (MEM_RESP_DATA),
    .wr_valid (!drop_fill_q && !ICACHE_INVALIDATE),
    .flush    (ICACHE_INVALIDATE)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vpn_d       = vpn_q;
    drop_fill_d = drop_fill_q;
    datablock_d = datablock_q;
    miss_line_d = miss_line_q;
    fill_en     = 1'b0;
    case (state_q)
      StIdle: begin
        drop_fill_d = 1'b0;
        if (ICACHE_REQ_VALID && TLB_REQ_VALID && !ICACHE_REQ_BITS_KILL) begin
          idx_d   = ICACHE_REQ_BITS_IDX[11:OFFSET_BITS];
          vpn_d   = TLB_REQ_BITS_VPN;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (ICACHE_REQ_BITS_KILL || fault) begin
          state_d = StIdle;
        end else if (hit) begin
          if (ICACHE_RESP_READY) begin
            datablock_d = rd_data;
            state_d     = StResp;
          end else begin
            state_d = StIdle;
          end
        end else begin
          miss_line_d = pa_line;
          state_d     = StMissReq;
        end
      end
      StResp: state_d = StIdle;
      StMissReq: begin
        drop_fill_d = drop_fill_q || ICACHE_INVALIDATE;
        if (MEM_REQ_READY) state_d = StMissWait;
      end
      StMissWait: begin
        drop_fill_d = drop_fill_q || ICACHE_INVALIDATE;
        if (MEM_RESP_VALID) begin
          fill_en     = 1'b1;
          drop_fill_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      vpn_q       <= '0;
      drop_fill_q <= 1'b0;
      datablock_q <= '0;
      miss_line_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vpn_q       <= vpn_d;
      drop_fill_q <= drop_fill_d;
      datablock_q <= datablock_d;
      miss_line_q <= miss_line_d;
    end
  end

  // Late kill in the response cycle still squashes the response.
  assign ICACHE_RESP_VALID          = (state_q == StResp) && !ICACHE_REQ_BITS_KILL;
  assign ICACHE_RESP_BITS_DATABLOCK = datablock_q;
  assign TLB_RESP_XCPT_IF           = (state_q == StLookup) && !ICACHE_REQ_BITS_KILL && fault;
  assign TLB_RESP_MISS              = 1'b0;
  assign PTWINVALIDATE              = 1'b0;
  assign MEM_REQ_VALID              = (state_q == StMissReq);
  assign MEM_REQ_ADDR               = {miss_line_q, {OFFSET_BITS{1'b0}}};

endmodule
